// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller / memory responder pair.
package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;

    // Every burst is an aligned block of BURST_LEN words; BEAT_W indexes a beat in it.
    localparam int BURST_LEN  = 4;
    localparam int BEAT_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } resp_state_t;

endpackage

// File: rtl/mem_dp_ram.sv
// Word-addressed RAM: one write port, one synchronous read port.
// A read and a write to the same word in one cycle return the old word.
module mem_dp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; only loads on a beat issue so the output holds between bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Memory-side burst target: accepts start/addr, returns an aligned 4-word
// burst as a valid-qualified beat stream LAT cycles after the accepted start.
// Each beat is issued to the RAM one cycle before it appears on rdata, so the
// FSM leaves BURST on the edge that issues beat 3 and is back in IDLE (able to
// accept a new start) in the cycle that shows rlast.
// Handshake: rvalid qualifies rdata for one cycle per beat with no back-pressure;
// rlast marks the final beat of an uninterrupted burst; cen low aborts a burst.
// LAT must be within 1..7.
module memory_responder
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rlast,
    output logic              busy,
    output logic              err
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    resp_state_t              state;
    logic [2:0]               lat_cnt;
    logic [BEAT_W-1:0]        beat_idx;
    logic [ADDR_W-BEAT_W-1:0] base;

    logic                     accept;
    logic                     issue;
    logic [ADDR_W-BEAT_W-1:0] issue_base;
    logic [BEAT_W-1:0]        issue_idx;
    logic                     unused_addr_lsb;

    // Word-select bits of the request address are not used: bursts are aligned.
    assign unused_addr_lsb = ^addr[BEAT_W-1:0];

    assign accept = (state == IDLE) && cen && start;

    // Decide whether a beat is sent to the RAM this cycle, and which word.
    always_comb begin
        issue      = 1'b0;
        issue_base = base;
        issue_idx  = beat_idx;
        case (state)
            IDLE: begin
                issue      = accept && (LAT == 1);
                issue_base = addr[ADDR_W-1:BEAT_W];
                issue_idx  = '0;
            end
            WAIT: begin
                issue     = cen && (lat_cnt == 3'd1);
                issue_idx = '0;
            end
            BURST: begin
                issue = cen;
            end
            default: begin
                issue = 1'b0;
            end
        endcase
    end

    // Responder FSM with latency counter, beat index and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            beat_idx <= '0;
            base     <= '0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rvalid <= issue;
            rlast  <= issue && (state == BURST) && (beat_idx == LAST_BEAT);
            err    <= cen && start && (state != IDLE);
            case (state)
                IDLE: begin
                    busy <= accept;
                    if (accept) begin
                        base <= addr[ADDR_W-1:BEAT_W];
                        if (LAT == 1) begin
                            state    <= BURST;
                            beat_idx <= BEAT_W'(1);
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 3'(LAT - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!cen) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        lat_cnt <= '0;
                    end else if (lat_cnt == 3'd1) begin
                        state    <= BURST;
                        beat_idx <= BEAT_W'(1);
                        lat_cnt  <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                BURST: begin
                    if (!cen) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        beat_idx <= '0;
                    end else begin
                        beat_idx <= beat_idx + BEAT_W'(1);
                        if (beat_idx == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mem_dp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (issue),
        .raddr ({issue_base, issue_idx}),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with LAT=2, one with LAT=1,
// sharing clock, reset and the loader port.
module tb_memory_responder;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [9:0]  waddr;
    logic [15:0] wdata;

    logic        cen2, start2;
    logic [9:0]  addr2;
    logic [15:0] rdata2;
    logic        rvalid2, rlast2, busy2, err2;

    logic        cen1, start1;
    logic [9:0]  addr1;
    logic [15:0] rdata1;
    logic        rvalid1, rlast1, busy1, err1;

    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    memory_responder #(.DATA_W(16), .ADDR_W(10), .LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .cen(cen2), .start(start2), .addr(addr2),
        .we(we), .waddr(waddr), .wdata(wdata),
        .rdata(rdata2), .rvalid(rvalid2), .rlast(rlast2), .busy(busy2), .err(err2)
    );

    memory_responder #(.DATA_W(16), .ADDR_W(10), .LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .cen(cen1), .start(start1), .addr(addr1),
        .we(we), .waddr(waddr), .wdata(wdata),
        .rdata(rdata1), .rvalid(rvalid1), .rlast(rlast1), .busy(busy1), .err(err1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [9:0] a, input logic [15:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    // Check the beat visible in the current cycle against the head of exp_q.
    task automatic beat_check(input string tag, input bit on_lat1, input logic last_exp);
        logic [15:0] exp;
        exp = exp_q.pop_front();
        if (on_lat1) begin
            check({tag, "_rvalid"}, 32'(rvalid1), 32'd1);
            check({tag, "_rdata"},  32'(rdata1),  32'(exp));
            check({tag, "_rlast"},  32'(rlast1),  32'(last_exp));
        end else begin
            check({tag, "_rvalid"}, 32'(rvalid2), 32'd1);
            check({tag, "_rdata"},  32'(rdata2),  32'(exp));
            check({tag, "_rlast"},  32'(rlast2),  32'(last_exp));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        cen2 = 1'b0; start2 = 1'b0; addr2 = '0;
        cen1 = 1'b0; start1 = 1'b0; addr1 = '0;

        // Reset state
        tick();
        tick();
        check("rst_rvalid2", 32'(rvalid2), 32'd0);
        check("rst_busy2",   32'(busy2),   32'd0);
        check("rst_rdata2",  32'(rdata2),  32'd0);
        check("rst_err1",    32'(err1),    32'd0);
        check("rst_rlast1",  32'(rlast1),  32'd0);
        rst_n = 1'b1;
        tick();

        // Preload: words 0x000..0x013 = 0xA000+i, words 0x3FC..0x3FF = 0xC000+i
        for (int i = 0; i < 20; i++) write_word(10'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++)  write_word(10'h3FC + 10'(i), 16'hC000 + 16'(i));
        cen1 = 1'b1;
        cen2 = 1'b1;
        tick();

        // T1: LAT=2, addr 0x004 -> A004..A007 in n+2..n+5, busy low in n+6
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA004 + 16'(i));
        start2 = 1'b1; addr2 = 10'h004;
        tick();
        start2 = 1'b0;
        check("t1_busy_n1",   32'(busy2),   32'd1);
        check("t1_rvalid_n1", 32'(rvalid2), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            beat_check($sformatf("t1_beat%0d", i), 1'b0, logic'(i == 3));
            check($sformatf("t1_busy_b%0d", i), 32'(busy2), 32'd1);
            tick();
        end
        check("t1_busy_end",   32'(busy2),   32'd0);
        check("t1_rvalid_end", 32'(rvalid2), 32'd0);

        // T2: LAT=1, addr 0x3FE -> words 0x3FC..0x3FF, no wrap to 0x000
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hC000 + 16'(i));
        start1 = 1'b1; addr1 = 10'h3FE;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_check($sformatf("t2_beat%0d", i), 1'b1, logic'(i == 3));
            tick();
        end
        check("t2_busy_end", 32'(busy1), 32'd0);
        tick();

        // T3: LAT=1 back-to-back, 0x000 then 0x008 started in the rlast cycle
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA008 + 16'(i));
        start1 = 1'b1; addr1 = 10'h000;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat_check($sformatf("t3_beat%0d", i), 1'b1, logic'(i == 3 || i == 7));
            if (i == 3) begin
                start1 = 1'b1; addr1 = 10'h008;
            end
            if (i == 4) check("t3_no_err", 32'(err1), 32'd0);
            tick();
            start1 = 1'b0;
        end
        check("t3_rvalid_end", 32'(rvalid1), 32'd0);
        check("t3_busy_end",   32'(busy1),   32'd0);
        tick();

        // T4: LAT=2, start during WAIT -> err pulse, first burst unchanged, no second
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
        start2 = 1'b1; addr2 = 10'h000;
        tick();
        addr2 = 10'h008;
        tick();
        start2 = 1'b0;
        check("t4_err_pulse", 32'(err2), 32'd1);
        for (int i = 0; i < 4; i++) begin
            beat_check($sformatf("t4_beat%0d", i), 1'b0, logic'(i == 3));
            if (i == 1) check("t4_err_clear", 32'(err2), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_no_second%0d", i), 32'(rvalid2), 32'd0);
            tick();
        end
        check("t4_busy_idle", 32'(busy2), 32'd0);

        // T5: LAT=2, drop cen while beat 1 is visible
        for (int i = 0; i < 2; i++) exp_q.push_back(16'hA004 + 16'(i));
        start2 = 1'b1; addr2 = 10'h004;
        tick();
        start2 = 1'b0;
        tick();
        beat_check("t5_beat0", 1'b0, 1'b0);
        tick();
        beat_check("t5_beat1", 1'b0, 1'b0);
        cen2 = 1'b0;
        tick();
        check("t5_rvalid_abort", 32'(rvalid2), 32'd0);
        check("t5_busy_abort",   32'(busy2),   32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_no_rlast%0d", i), 32'(rlast2), 32'd0);
            tick();
        end
        cen2 = 1'b1;

        // T6: LAT=1, reset mid-burst, then read-before-write at 0x010
        exp_q.push_back(16'hA000);
        exp_q.push_back(16'hA001);
        start1 = 1'b1; addr1 = 10'h000;
        tick();
        start1 = 1'b0;
        beat_check("t6_beat0", 1'b1, 1'b0);
        tick();
        beat_check("t6_beat1", 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", 32'(rvalid1), 32'd0);
        check("t6_rst_busy",   32'(busy1),   32'd0);
        check("t6_rst_rdata",  32'(rdata1),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_rvalid", 32'(rvalid1), 32'd0);
        check("t6_post_busy",   32'(busy1),   32'd0);

        exp_q.push_back(16'hA010);
        exp_q.push_back(16'hA011);
        exp_q.push_back(16'hA012);
        exp_q.push_back(16'hA013);
        start1 = 1'b1; addr1 = 10'h010;
        we = 1'b1; waddr = 10'h010; wdata = 16'h1234;
        tick();
        start1 = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_check($sformatf("t6_rbw%0d", i), 1'b1, logic'(i == 3));
            tick();
        end
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hA011);
        exp_q.push_back(16'hA012);
        exp_q.push_back(16'hA013);
        start1 = 1'b1; addr1 = 10'h011;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_check($sformatf("t6_new%0d", i), 1'b1, logic'(i == 3));
            tick();
        end
        check("t6_busy_end", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Memory-side target for the memory controller's burst protocol. Samples `cen`/`start`/`addr` from the controller, fetches a 4-word aligned burst from an internal word-addressed RAM, and returns it as a valid-qualified beat stream after a programmable latency. A separate write port preloads or updates the array (test loader, DMA side).

## Interface
- `DATA_W`, 16: data word width.
- `ADDR_W`, 10: word address width; array depth is 2^ADDR_W.
- `LAT`, 2: cycles from accepted `start` to first beat; legal range 1..7.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cen`  in  1  chip enable from the controller; low aborts any burst.
- `start`  in  1  burst request, sampled only with `cen`=1.
- `addr`  in  ADDR_W  request address; `addr[1:0]` ignored; the base is `{addr[ADDR_W-1:2],2'b00}`.
- `we`  in  1  write strobe for the loader port.
- `waddr`  in  ADDR_W  write address.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  burst beat data, valid only with `rvalid`.
- `rvalid`  out  1  beat valid.
- `rlast`  out  1  high with the 4th beat only.
- `busy`  out  1  high from accepted `start` until the cycle after the last beat.
- `err`  out  1  one-cycle pulse when a `start` is dropped.

## Operation
- Reset (`rst_n`=0, asynchronous): state IDLE; `rdata`=0, `rvalid`=0, `rlast`=0, `busy`=0, `err`=0; latency and beat counters cleared. RAM contents are not reset.
- States: IDLE, WAIT, BURST.
- IDLE: `cen`&`start` -> latch the base, load the latency counter with LAT-1, set `busy`, go to WAIT. `start` with `cen`=0 is ignored without raising `err`.
- WAIT: count down. At 0, go to BURST with beat index 0.
- BURST: each cycle, drive the word at base+index with `rvalid`=1. Increment index as a 2-bit counter. At index 3, assert `rlast` and return to IDLE.
- Burst addresses wrap within the aligned 4-word block only. The base's upper bits never change during a burst.
- `start` while `busy`: ignored; `err` pulses for one cycle. The current burst is unaffected.
- `cen`=0 in WAIT or BURST: abort. Next cycle: IDLE, `rvalid`=0, `rlast`=0, `busy`=0. No partial `rlast` is issued.
- Loader write: `we` writes `wdata` to `waddr` at the edge, in any state. A read and a write to the same word in the same cycle returns the old data (read-before-write).
- `err` and `rlast` are both single-cycle pulses.

## Timing
- `start` accepted in cycle n -> beats in cycles n+LAT .. n+LAT+3, `rlast` in n+LAT+3.
- `busy` is high in cycles n+1 .. n+LAT+3. A new `start` is accepted in cycle n+LAT+3 (same cycle as `rlast`), so back-to-back bursts have zero idle beats between them.
- Outputs are registered; there is no combinational path from inputs to outputs.
- RAM read is synchronous, 1 cycle. The read address is issued one cycle ahead of the beat, which is why LAT≥1.
- Reset asserted mid-burst: outputs clear immediately, independent of `clk`. After deassertion the first edge sees IDLE.

## Structure
- Package `mem_pkg`:
  - `BURST_LEN`=4
  - `BEAT_W`=2
  - the `resp_state_t` enum {IDLE, WAIT, BURST}
  - `ADDR_W`/`DATA_W` defaults, shared with the controller
- Sub-module `mem_dp_ram`: one write port, one synchronous read port, read-before-write, parameterised by `DATA_W`/`ADDR_W`. The responder FSM and counters live in `memory_responder`.

## Test plan
- Load words 0..7 with 0xA000+i; `start` with `addr`=0x004, LAT=2. Required: `rdata` 0xA004..0xA007 in cycles n+2..n+5, `rlast` in n+5, `busy` low in n+6.
- `start` with `addr`=0x3FE, LAT=1. Required: beats from words 0x3FC..0x3FF (alignment), no access at 0x000.
- Back-to-back: second `start` with `addr`=0x008 in the `rlast` cycle of a burst from 0x000. Required: 8 contiguous `rvalid` beats, two `rlast` pulses.
- `start` during WAIT. Required: `err` pulse one cycle later; first burst completes unchanged; no second burst.
- Drop `cen` after beat 1. Required: `rvalid`=0 and `busy`=0 the next cycle; `rlast` never asserted.
- Assert `rst_n`=0 mid-BURST, release, then write 0x1234 to 0x010 while reading 0x010. Required: outputs 0 immediately on reset; the beat returns the old value; a subsequent burst returns 0x1234.
